// File: rtl/periph_bus_master.sv
// Initiator side of the peripheral register bus. Turns one CPU load/store at a
// time into a single peripheral transaction and returns one response per request.
module periph_bus_master #(
   parameter logic [31:0] PERI_BASE = 32'hFFFF_F000,
   parameter logic [31:0] PERI_MASK = 32'hFFFF_F000,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        peri_wen,
   output logic [31:0] peri_addr,
   output logic [31:0] peri_wdata,
   input  logic [31:0] peri_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RD_WAIT,
      RESP
   } state_t;

   localparam logic [3:0] RdLat = 4'(RD_LAT);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Out-of-window requests skip the bus entirely and leave peri_* untouched.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if ((req_addr & PERI_MASK) != PERI_BASE) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = 32'd0;
               end else begin
                  addr_d = req_addr;
                  if (req_we) begin
                     state_d = WRITE;
                     wdata_d = req_wdata;
                  end else begin
                     state_d = RD_WAIT;
                     cnt_d   = 4'd0;
                  end
               end
            end
         end
         WRITE: begin
            state_d = RESP;
            rdata_d = 32'd0;
            err_d   = 1'b0;
         end
         RD_WAIT: begin
            if (cnt_q == RdLat) begin
               state_d = RESP;
               rdata_d = peri_rdata;
               err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign peri_wen   = (state_q == WRITE);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign peri_addr  = addr_q;
   assign peri_wdata = wdata_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Scoreboard bench for periph_bus_master: three instances (RD_LAT 1, 3, 0) share
// the request stream; one monitor per instance checks its responses and strobes.
module tb_periph_bus_master;

   localparam logic [31:0] Base = 32'hFFFF_F000;
   localparam logic [31:0] Mask = 32'hFFFF_F000;

   typedef struct {
      logic        err;
      logic [31:0] data;
      logic [1:0]  kind;
      int          e0;
   } expT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reqValid = 1'b0;
   logic        reqWe = 1'b0;
   logic [31:0] reqAddr = 32'd0;
   logic [31:0] reqWdata = 32'd0;
   logic        respReady = 1'b1;

   logic [2:0]  reqReady;
   logic [2:0]  respValid;
   logic [2:0]  respErr;
   logic [2:0]  periWen;
   logic [31:0] respRdata [3];
   logic [31:0] periAddr [3];
   logic [31:0] periWdata [3];

   expT         shQ[$];
   int          rdIdx [3];
   bit          seenFirst [3];
   int          cyc = 0;
   int          wenCyc = -1;
   logic [31:0] expWAddr = 32'd0;
   logic [31:0] expWData = 32'd0;
   logic [31:0] lastAddr = 32'd0;
   logic [31:0] lastWdata = 32'd0;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] respData(input logic [31:0] a);
      case (a)
         32'hFFFF_F020: return 32'hCAFE_0001;
         32'hFFFF_F024: return 32'hCAFE_0002;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic int expLat(input logic [1:0] kind, input int lat);
      case (kind)
         2'd0:    return 2;
         2'd1:    return lat + 2;
         default: return 1;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gDut
      localparam int Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
      logic [31:0] rdLocal;
      expT         e;

      // A zero-latency responder must present data in the address cycle itself.
      if (Lat == 0) begin : gComb
         always_comb rdLocal = respData(periAddr[g]);
      end else begin : gReg
         always @(posedge clk or posedge rst) begin
            if (rst) rdLocal <= 32'd0;
            else     rdLocal <= respData(periAddr[g]);
         end
      end

      periph_bus_master #(
         .PERI_BASE(Base),
         .PERI_MASK(Mask),
         .RD_LAT   (Lat)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (reqValid),
         .req_ready (reqReady[g]),
         .req_we    (reqWe),
         .req_addr  (reqAddr),
         .req_wdata (reqWdata),
         .resp_valid(respValid[g]),
         .resp_ready(respReady),
         .resp_rdata(respRdata[g]),
         .resp_err  (respErr[g]),
         .peri_wen  (periWen[g]),
         .peri_addr (periAddr[g]),
         .peri_wdata(periWdata[g]),
         .peri_rdata(rdLocal)
      );

      always @(negedge clk) begin
         if (rst) begin
            rdIdx[g]     = shQ.size();
            seenFirst[g] = 1'b0;
         end else begin
            checkOutput($sformatf("lat%0d peri_wen", Lat), 32'(periWen[g]), 32'(cyc == wenCyc));
            if (cyc == wenCyc) begin
               checkOutput($sformatf("lat%0d peri_addr", Lat), periAddr[g], expWAddr);
               checkOutput($sformatf("lat%0d peri_wdata", Lat), periWdata[g], expWData);
            end
            if (respValid[g]) begin
               if (rdIdx[g] >= shQ.size()) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL lat%0d unexpected response: got resp_valid 1, expected 0 at cycle %0d", Lat, cyc);
               end else begin
                  e = shQ[rdIdx[g]];
                  if (!seenFirst[g]) begin
                     checkOutput($sformatf("lat%0d resp latency", Lat), cyc, e.e0 + expLat(e.kind, Lat) - 1);
                     seenFirst[g] = 1'b1;
                  end
                  checkOutput($sformatf("lat%0d resp_rdata", Lat), respRdata[g], e.data);
                  checkOutput($sformatf("lat%0d resp_err", Lat), 32'(respErr[g]), 32'(e.err));
                  if (respReady) begin
                     rdIdx[g]++;
                     seenFirst[g] = 1'b0;
                  end
               end
            end
         end
      end
   end

   task automatic checkResetAll();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("dut%0d reset req_ready", i), 32'(reqReady[i]), 32'd1);
         checkOutput($sformatf("dut%0d reset resp_valid", i), 32'(respValid[i]), 32'd0);
         checkOutput($sformatf("dut%0d reset resp_err", i), 32'(respErr[i]), 32'd0);
         checkOutput($sformatf("dut%0d reset peri_wen", i), 32'(periWen[i]), 32'd0);
         checkOutput($sformatf("dut%0d reset resp_rdata", i), respRdata[i], 32'd0);
         checkOutput($sformatf("dut%0d reset peri_addr", i), periAddr[i], 32'd0);
         checkOutput($sformatf("dut%0d reset peri_wdata", i), periWdata[i], 32'd0);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output int e0);
      int  n;
      bit  inWin;
      expT x;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = wdata;
      reqValid = 1'b1;
      n = 0;
      while (reqReady != 3'b111 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept timeout: got req_ready %b, expected 111", reqReady);
         reqValid = 1'b0;
         e0 = -100;
         return;
      end
      @(posedge clk);
      #1;
      e0       = cyc;
      reqValid = 1'b0;
      inWin    = ((addr & Mask) == Base);
      x.e0     = e0;
      x.err    = !inWin;
      x.kind   = !inWin ? 2'd2 : (we ? 2'd0 : 2'd1);
      x.data   = (inWin && !we) ? respData(addr) : 32'd0;
      if (inWin) lastAddr = addr;
      if (inWin && we) begin
         wenCyc    = e0;
         expWAddr  = addr;
         expWData  = wdata;
         lastWdata = wdata;
      end
      shQ.push_back(x);
   endtask

   task automatic waitIdle();
      int n;
      bit drained;
      n = 0;
      drained = 1'b0;
      while (!drained && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         drained = (reqReady == 3'b111) && (respValid == 3'b000) &&
                   (rdIdx[0] == shQ.size()) && (rdIdx[1] == shQ.size()) && (rdIdx[2] == shQ.size());
      end
      if (!drained) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain timeout: got req_ready %b resp_valid %b, expected 111 and 000", reqReady, respValid);
      end
   endtask

   initial begin
      int e0a, e0b, r;
      repeat (3) @(posedge clk);
      #1;
      checkResetAll();
      rst = 1'b0;

      applyStimulus(1'b1, 32'hFFFF_F020, 32'h0000_1234, e0a);
      waitIdle();
      applyStimulus(1'b0, 32'hFFFF_F020, 32'd0, e0a);
      waitIdle();

      applyStimulus(1'b0, 32'h0000_1000, 32'd0, e0a);
      waitIdle();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("dut%0d err keeps peri_addr", i), periAddr[i], lastAddr);
         checkOutput($sformatf("dut%0d err keeps peri_wdata", i), periWdata[i], lastWdata);
      end

      applyStimulus(1'b1, 32'hFFFF_F024, 32'h5555_AAAA, e0a);
      waitIdle();
      applyStimulus(1'b0, 32'hFFFF_F024, 32'd0, e0a);
      waitIdle();
      applyStimulus(1'b1, 32'h1234_5678, 32'hFFFF_FFFF, e0a);
      waitIdle();
      applyStimulus(1'b0, 32'hFFFF_F100, 32'd0, e0a);
      waitIdle();

      // Back-to-back stores with the request held: one accept every third edge.
      applyStimulus(1'b1, 32'hFFFF_F020, 32'h0000_0011, e0a);
      applyStimulus(1'b1, 32'hFFFF_F024, 32'h0000_0022, e0b);
      checkOutput("b2b store spacing", e0b - e0a, 32'd3);
      waitIdle();

      respReady = 1'b0;
      applyStimulus(1'b0, 32'hFFFF_F020, 32'd0, e0a);
      reqWe    = 1'b0;
      reqAddr  = 32'hFFFF_F024;
      reqValid = 1'b1;
      repeat (8) begin
         checkOutput("stall req_ready", 32'(reqReady), 32'd0);
         @(posedge clk);
         #1;
      end
      respReady = 1'b1;
      r = cyc;
      applyStimulus(1'b0, 32'hFFFF_F024, 32'd0, e0b);
      checkOutput("accept after backpressure", e0b, r + 2);
      waitIdle();

      applyStimulus(1'b0, 32'hFFFF_F020, 32'd0, e0a);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      wenCyc    = -1;
      lastAddr  = 32'd0;
      lastWdata = 32'd0;
      #1;
      checkResetAll();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      applyStimulus(1'b0, 32'hFFFF_F024, 32'd0, e0a);
      waitIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/periph_bus_master.md
Name: periph_bus_master

Overview:
- Initiator side of the peripheral register bus: converts CPU load/store requests into single peripheral bus transactions.
- Drives peri_wen/peri_addr/peri_wdata and captures the responder's registered peri_rdata after a fixed read latency.
- Returns one response per request to the CPU over a valid/ready pair.
- Sits between the CPU memory stage and the peripheral responders (timer, frequency register, etc.). One transaction is outstanding at a time.

Parameters:
- PERI_BASE, 32'hFFFF_F000, base of the peripheral window.
- PERI_MASK, 32'hFFFF_F000, address bits compared against PERI_BASE.
- RD_LAT, 1, peripheral read latency in cycles, legal range 0..15.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  CPU request valid
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response valid
- resp_ready  input  1  CPU accepts the response
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  address outside the peripheral window
- peri_wen  output  1  peripheral write strobe, one cycle per store
- peri_addr  output  32  peripheral address, registered
- peri_wdata  output  32  peripheral write data, registered
- peri_rdata  input  32  responder read data (registered inside the responder)

Behaviour:
- Reset (async, rst high): state IDLE; req_ready=1; resp_valid=0; resp_err=0; peri_wen=0; resp_rdata, peri_addr, peri_wdata all 0. Latency counter = 0.
- Reset asserted mid-transaction drops the transaction entirely: no response and no further peri_wen pulse.
- All outputs are registered or decoded from state only. No combinational path from req_* or resp_ready to any output.
- State IDLE:
  - req_ready=1.
  - Handshake when req_valid & req_ready at edge E0: latch we/addr/wdata.
  - peri_addr <= req_addr at E0 for in-window requests; it holds until the next accepted in-window request.
  - If (req_addr & PERI_MASK) != PERI_BASE: go to RESP with resp_err=1 and resp_rdata=0. No bus activity; peri_* unchanged.
  - Else if req_we=1: go to WRITE; peri_wdata <= req_wdata at E0.
  - Else: go to RD_WAIT; counter <= 0.
- State WRITE: lasts exactly 1 cycle (cycle 1); peri_wen=1 only in this cycle. Next state RESP with resp_rdata=0, resp_err=0.
- State RD_WAIT:
  - peri_wen=0; counter increments each cycle.
  - When counter == RD_LAT: resp_rdata <= peri_rdata, then go to RESP.
  - RD_WAIT therefore spans RD_LAT+1 cycles.
  - With RD_LAT=1, capture occurs at the end of cycle 2, i.e. the responder value registered one cycle after the address was presented.
- State RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable while resp_ready=0.
  - On resp_valid & resp_ready, go to IDLE and clear resp_valid and resp_err. resp_rdata holds its last value.
- req_ready=0 in every state except IDLE. A request cannot be accepted in the same cycle a response completes; the earliest next accept is the cycle after.
- Response latency from accept to resp_valid (with resp_ready=1):
  - store: 2 cycles
  - load: RD_LAT+2 cycles
  - error: 1 cycle
- Back-to-back throughput with resp_ready tied 1: one store per 3 cycles.
- Counter is 4 bits wide. RD_LAT values above 15 are unsupported.

Test Plan:
- Store: reset, then req (we=1, addr=32'hFFFF_F020, wdata=32'h0000_1234) accepted at E0 → peri_wen=1 only in cycle 1 with peri_addr=32'hFFFF_F020 and peri_wdata=32'h1234; resp_valid in cycle 2 with rdata=0, err=0.
- Load, RD_LAT=1: model a responder that returns 32'hCAFE_0001 one cycle after the address; load addr=32'hFFFF_F020 → resp_valid at cycle 3 with resp_rdata=32'hCAFE_0001; peri_wen never asserted.
- Out-of-window: load addr=32'h0000_1000 → resp_valid at cycle 1 with resp_err=1, rdata=0; peri_addr and peri_wen unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after a load → resp_valid and resp_rdata stable, req_ready=0, and a second req_valid is not accepted; raise resp_ready → IDLE next cycle, and the pending request is accepted the cycle after.
- Reset mid-read, RD_LAT=3: assert rst during RD_WAIT → all outputs return to reset values immediately; no resp_valid and no peri_wen afterwards; the next load completes normally.
- RD_LAT=0 build: load returns the value present on peri_rdata in cycle 1; resp_valid at cycle 2.
